// File: rtl/out_uart_tx_if.sv
// out_uart_tx_if
// Groups the signals between the core-side capture logic, the UART
// reporter and whoever watches it.
//   out_cpu    : result nibble from the core
//   cap_en     : capture enable
//   tx         : UART serial line, idles high
//   busy       : reporter has work in flight or queued
//   overflow   : sticky, a capture was dropped on a full FIFO
//   fifo_count : number of queued values
// The master modport drives out_cpu/cap_en.
// The slave modport (the reporter itself) drives the status and line outputs.
interface out_uart_tx_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]    out_cpu;
    logic          cap_en;
    logic          tx;
    logic          busy;
    logic          overflow;
    logic [CW-1:0] fifo_count;

    modport master (
        output out_cpu,
        output cap_en,
        input  tx,
        input  busy,
        input  overflow,
        input  fifo_count
    );

    modport slave (
        input  out_cpu,
        input  cap_en,
        output tx,
        output busy,
        output overflow,
        output fifo_count
    );
endinterface

// File: rtl/out_uart_tx.sv
// out_uart_tx
// Watches the core's 4-bit result, queues every change in a small
// first-word-fall-through FIFO, and sends each queued value to a host as one
// ASCII hex character. The framing is 8N1, and each character is optionally
// followed by a newline frame.
//   CLK   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : out_uart_tx_if.slave
//           inputs:  out_cpu, cap_en
//           outputs: tx, busy, overflow, fifo_count
module out_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8,
    parameter int SEND_NEWLINE = 1
) (
    input  logic          CLK,
    input  logic          reset,
    out_uart_tx_if.slave  bus
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    byte_q, byte_d;
    logic          hex_q, hex_d;
    logic          tx_q, tx_d;

    logic [3:0]    prev_q;
    logic [3:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    logic          empty, full, push_req, push, drop, pop, baud_last;
    logic [3:0]    head;

    function automatic logic [7:0] hex_char(input logic [3:0] v);
        if (v < 4'd10)
            return 8'h30 + {4'h0, v};
        else
            return 8'h37 + {4'h0, v};
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_COUNT);
    assign head      = mem[rd_ptr];
    assign baud_last = (baud_q == BAUD_LAST);

    // A full FIFO still accepts a push when the transmitter pops on the same
    // edge, because the slot being freed is the one written.
    assign push_req = bus.cap_en && (bus.out_cpu != prev_q);
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // Capture history, FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            prev_q     <= 4'h0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (bus.cap_en)
                prev_q <= bus.out_cpu;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (drop)
                overflow_q <= 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage needs no reset; the occupancy count says what is valid
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= bus.out_cpu;
    end

    // Transmit state registers; tx is registered so the line never glitches
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= 3'd0;
            byte_q  <= 8'h00;
            hex_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            hex_q   <= hex_d;
            tx_q    <= tx_d;
        end
    end

    // Next state: the baud counter restarts on every state or bit change.
    // hex_q remembers whether the frame in flight is the character, so a
    // newline goes out after it.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BW'(1);
        idx_d   = idx_q;
        byte_d  = byte_q;
        hex_d   = hex_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    byte_d  = hex_char(head);
                    hex_d   = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (idx_q == 3'd7)
                        state_d = STOP;
                    else
                        idx_d = idx_q + 3'd1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (SEND_NEWLINE != 0 && hex_q) begin
                        byte_d  = 8'h0A;
                        hex_d   = 1'b0;
                        state_d = START;
                    end else if (!empty) begin
                        pop     = 1'b1;
                        byte_d  = hex_char(head);
                        hex_d   = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line level is derived from where the FSM is heading, so it lines up
    // with the registered state
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = byte_d[idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = (state_q != IDLE) || !empty;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_out_uart_tx.sv
// tb_out_uart_tx
// Directed bench for out_uart_tx at 4 clocks per bit.
// It uses one reporter with newline frames and one without.
// Frames are decoded from the tx line by sampling the second cycle of each bit.
module tb_out_uart_tx;
    logic CLK;
    logic reset;
    int   assert_count;
    int   fail_count;

    out_uart_tx_if #(.FIFO_DEPTH(8)) bus ();
    out_uart_tx_if #(.FIFO_DEPTH(8)) bus0 ();

    out_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .SEND_NEWLINE(1)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    out_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .SEND_NEWLINE(0)) dut_nl0 (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected run to finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic tx_of(input int sel);
        return (sel == 1) ? bus0.tx : bus.tx;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 1) ? bus0.busy : bus.busy;
    endfunction

    task automatic applyStimulus(input int sel, input logic [3:0] val, input logic en);
        @(negedge CLK);
        if (sel == 1) begin
            bus0.out_cpu = val;
            bus0.cap_en  = en;
        end else begin
            bus.out_cpu = val;
            bus.cap_en  = en;
        end
    endtask

    // Waits for a start bit and decodes one frame.
    // The task returns positioned at the last cycle of the stop bit.
    task automatic recvByte(input int sel, input string tag, output logic [7:0] data, output int waited);
        logic seen;
        seen   = 1'b0;
        waited = 0;
        data   = 8'h00;
        while (!seen && waited < 400) begin
            @(negedge CLK);
            waited++;
            if (tx_of(sel) == 1'b0)
                seen = 1'b1;
        end
        if (!seen) begin
            checkOutput({tag, "_start_seen"}, 32'(tx_of(sel)), 32'd0);
            data = 8'hFF;
            return;
        end
        @(negedge CLK);
        checkOutput({tag, "_startbit"}, 32'(tx_of(sel)), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge CLK);
            data[i] = tx_of(sel);
        end
        repeat (4) @(negedge CLK);
        checkOutput({tag, "_stopbit"}, 32'(tx_of(sel)), 32'd1);
        repeat (2) @(negedge CLK);
    endtask

    task automatic watchIdle(input int sel, input int cycles, output int lows, output int busy_hi);
        lows    = 0;
        busy_hi = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if (tx_of(sel) == 1'b0) lows++;
            if (busy_of(sel) == 1'b1) busy_hi++;
        end
    endtask

    initial begin
        logic [7:0] b;
        int         w;
        int         lows;
        int         bhi;
        logic [7:0] exp_seq [18];

        assert_count = 0;
        fail_count   = 0;
        bus.out_cpu  = 4'h0;
        bus.cap_en   = 1'b0;
        bus0.out_cpu = 4'h0;
        bus0.cap_en  = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge CLK);
        checkOutput("reset_tx", 32'(bus.tx), 32'd1);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_overflow", 32'(bus.overflow), 32'd0);
        checkOutput("reset_count", 32'(bus.fifo_count), 32'd0);
        reset = 1'b0;

        // Scenario 1: a constant zero after reset is never reported
        $display("[TB] scenario 1: zero held after reset");
        bus.cap_en = 1'b1;
        watchIdle(0, 100, lows, bhi);
        checkOutput("s1_tx_low_cycles", 32'(lows), 32'd0);
        checkOutput("s1_busy_cycles", 32'(bhi), 32'd0);
        checkOutput("s1_count", 32'(bus.fifo_count), 32'd0);
        checkOutput("s1_overflow", 32'(bus.overflow), 32'd0);

        // Scenario 2: 0->5 gives '5' then a newline, back to back
        $display("[TB] scenario 2: single value with newline");
        applyStimulus(0, 4'h5, 1'b1);
        recvByte(0, "s2_char", b, w);
        checkOutput("s2_char_latency", 32'(w), 32'd2);
        checkOutput("s2_char_byte", 32'(b), 32'h35);
        recvByte(0, "s2_nl", b, w);
        checkOutput("s2_nl_gap", 32'(w), 32'd1);
        checkOutput("s2_nl_byte", 32'(b), 32'h0A);
        checkOutput("s2_busy_last_cycle", 32'(bus.busy), 32'd1);
        @(negedge CLK);
        checkOutput("s2_busy_after", 32'(bus.busy), 32'd0);

        // Scenario 3: no newline frames when SEND_NEWLINE is 0
        $display("[TB] scenario 3: no newline variant");
        applyStimulus(1, 4'hB, 1'b1);
        recvByte(1, "s3_b", b, w);
        checkOutput("s3_b_latency", 32'(w), 32'd2);
        checkOutput("s3_b_byte", 32'(b), 32'h42);
        @(negedge CLK);
        checkOutput("s3_busy_after_b", 32'(bus0.busy), 32'd0);
        applyStimulus(1, 4'hF, 1'b1);
        recvByte(1, "s3_f", b, w);
        checkOutput("s3_f_latency", 32'(w), 32'd2);
        checkOutput("s3_f_byte", 32'(b), 32'h46);
        watchIdle(1, 60, lows, bhi);
        checkOutput("s3_no_extra_frames", 32'(lows), 32'd0);

        // Scenario 4: twelve changes on consecutive edges overflow the FIFO
        $display("[TB] scenario 4: FIFO overflow");
        for (int i = 0; i < 9; i++) begin
            exp_seq[2*i]     = 8'h31 + 8'(i);
            exp_seq[2*i + 1] = 8'h0A;
        end
        fork
            begin
                for (int k = 0; k <= 12; k++) begin
                    @(negedge CLK);
                    if (k > 0) begin
                        checkOutput($sformatf("s4_count_e%0d", k - 1), 32'(bus.fifo_count),
                                    (k - 1 < 2) ? 32'd1 : ((k - 1 > 8) ? 32'd8 : 32'(k - 1)));
                        checkOutput($sformatf("s4_overflow_e%0d", k - 1), 32'(bus.overflow),
                                    (k - 1 >= 9) ? 32'd1 : 32'd0);
                    end
                    if (k < 12)
                        bus.out_cpu = 4'(k + 1);
                end
            end
            begin
                for (int f = 0; f < 18; f++) begin
                    recvByte(0, $sformatf("s4_f%0d", f), b, w);
                    checkOutput($sformatf("s4_byte%0d", f), 32'(b), 32'(exp_seq[f]));
                    if (f > 0)
                        checkOutput($sformatf("s4_gap%0d", f), 32'(w), 32'd1);
                end
            end
        join
        @(negedge CLK);
        checkOutput("s4_busy_after", 32'(bus.busy), 32'd0);
        checkOutput("s4_count_after", 32'(bus.fifo_count), 32'd0);
        checkOutput("s4_overflow_sticky", 32'(bus.overflow), 32'd1);
        watchIdle(0, 50, lows, bhi);
        checkOutput("s4_no_dropped_sent", 32'(lows), 32'd0);

        // Scenario 5: asynchronous reset in the middle of a data bit
        $display("[TB] scenario 5: async reset mid frame");
        applyStimulus(0, 4'h4, 1'b1);
        applyStimulus(0, 4'h6, 1'b1);
        repeat (6) @(negedge CLK);
        checkOutput("s5_pre_tx", 32'(bus.tx), 32'd0);
        checkOutput("s5_pre_count", 32'(bus.fifo_count), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("s5_tx", 32'(bus.tx), 32'd1);
        checkOutput("s5_count", 32'(bus.fifo_count), 32'd0);
        checkOutput("s5_busy", 32'(bus.busy), 32'd0);
        checkOutput("s5_overflow", 32'(bus.overflow), 32'd0);
        bus.out_cpu = 4'h0;
        @(negedge CLK);
        reset = 1'b0;
        watchIdle(0, 100, lows, bhi);
        checkOutput("s5_post_tx_low", 32'(lows), 32'd0);
        checkOutput("s5_post_busy", 32'(bhi), 32'd0);

        // Scenario 6: prev_q holds while capture is disabled
        $display("[TB] scenario 6: capture disabled then re-enabled");
        applyStimulus(0, 4'h7, 1'b0);
        applyStimulus(0, 4'h3, 1'b0);
        @(negedge CLK);
        checkOutput("s6_disabled_count", 32'(bus.fifo_count), 32'd0);
        checkOutput("s6_disabled_tx", 32'(bus.tx), 32'd1);
        applyStimulus(0, 4'h3, 1'b1);
        recvByte(0, "s6_char", b, w);
        checkOutput("s6_char_latency", 32'(w), 32'd2);
        checkOutput("s6_char_byte", 32'(b), 32'h33);
        recvByte(0, "s6_nl", b, w);
        checkOutput("s6_nl_byte", 32'(b), 32'h0A);
        watchIdle(0, 100, lows, bhi);
        checkOutput("s6_no_more_frames", 32'(lows), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule

// File: doc/out_uart_tx.md
Name: out_uart_tx

Overview:
- Consumes the core's 4-bit `out_cpu` result nibble and reports it to a host over a UART line.
- Detects each change of `out_cpu` and buffers the new value in a small FIFO.
- Transmits each buffered value as an ASCII hex character, 8N1 framing, optionally followed by a newline.
- Sits directly downstream of the core at the top level.

Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or more.
- `FIFO_DEPTH`, 8: capture FIFO entries. Must be a power of 2, 2 or more.
- `SEND_NEWLINE`, 1: when 1, each hex character is followed by an 0x0A frame.

Ports:
- `CLK`, input, 1: system clock. All logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `out_cpu`, input, 4: result nibble from the core. May change every cycle.
- `cap_en`, input, 1: capture enable.
- `tx`, output, 1: UART serial output. Idles high.
- `busy`, output, 1: high while the transmit FSM is not in IDLE or the FIFO is non-empty.
- `overflow`, output, 1: sticky flag. Set when a capture is dropped because the FIFO is full.
- `fifo_count`, output, $clog2(FIFO_DEPTH)+1: current number of FIFO entries.

Behaviour:
- Reset, asserted asynchronously: all state takes its reset value immediately.
  - Outputs: `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0.
  - Internal: FSM goes to IDLE, FIFO pointers are 0, `prev_q`=0.
  - Any partial frame is abandoned and is not resumed after reset release.
- Capture (each edge with `cap_en`=1):
  - If `out_cpu` != `prev_q`, push `out_cpu`.
  - `prev_q` loads `out_cpu` on every edge with `cap_en`=1.
  - With `cap_en`=0, `prev_q` holds and nothing is pushed. On re-enable, the comparison is against the held `prev_q`.
  - Because `prev_q` resets to 0, a value of 0 after reset is not sent.
- FIFO:
  - Synchronous and first-word-fall-through.
  - A push while full, with no pop on the same edge: value dropped, `overflow` set to 1. It clears only on reset.
  - Push and pop on the same edge while full: push is accepted, `fifo_count` is unchanged, `overflow` is not set.
  - Push and pop on the same edge while empty cannot occur, because a pop requires non-empty at the edge.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Character encoding:
  - v 0-9 maps to 0x30+v.
  - v 10-15 maps to 0x41+(v-10).
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty at an edge: pop, latch the encoded byte, go to START. This happens on the edge after the capture edge, so `tx` falls one cycle after capture.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with the bit index at 0.
  - DATA: `tx`=byte[idx] for `CLKS_PER_BIT` cycles each, LSB first. After idx 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At the end of STOP, in priority order:
    1. If `SEND_NEWLINE`=1 and the just-sent byte was the hex character: load 0x0A, go to START.
    2. Else if the FIFO is non-empty: pop, load, go to START.
    3. Else go to IDLE.
  - There is no idle gap between back-to-back frames.
- Timing:
  - Baud counter is `$clog2(CLKS_PER_BIT)` bits wide, counts 0 to `CLKS_PER_BIT`-1, and reloads on every state or bit change.
  - One frame is exactly 10*`CLKS_PER_BIT` cycles.
  - One value is 20*`CLKS_PER_BIT` cycles when `SEND_NEWLINE`=1.
- Registered outputs: `tx` comes from a register (glitch-free). `fifo_count` and `overflow` are registered. `busy` is combinational from state and count.

Test Plan:
All scenarios use `CLKS_PER_BIT`=4, `FIFO_DEPTH`=8, `SEND_NEWLINE`=1 unless stated.
1. Reset, then hold `out_cpu`=0 with `cap_en`=1 for 100 cycles -> `tx`=1 throughout, `busy`=0, `fifo_count`=0, `overflow`=0.
2. `out_cpu` 0->5 at edge E0 -> `tx` low from E1. Bit sequence on `tx`, 4 cycles per bit:
   - Frame 0x35: 0, 1,0,1,0,1,1,0,0, 1.
   - Immediately followed by frame 0x0A: 0, 0,1,0,1,0,0,0,0, 1.
   - `busy` falls after 80 cycles.
3. `out_cpu`=0xB, then with `SEND_NEWLINE`=0 `out_cpu`=0xF -> frames 0x42 then 0x46 only, each 40 cycles, no 0x0A frames.
4. Change `out_cpu` on 12 consecutive edges E0-E11 -> 9 values accepted (E0-E8), 3 dropped, `overflow`=1 from E9, `fifo_count` peaks at 8. Exactly the first 9 values are transmitted, in order.
5. Assert `reset` mid-DATA of a frame, asynchronously, between clock edges -> `tx`=1 immediately, `fifo_count`=0, `busy`=0. After release there is no further output.
6. `cap_en`=0 while `out_cpu` goes 0->7->3, then `cap_en`=1 with `out_cpu` held at 3 -> exactly one frame pair, '3' (0x33) then 0x0A. Holding the value constant afterwards produces no more frames.
